// File: rtl/button_debounce_repeat_pkg.sv
// Shared types and helpers for the push-button conditioning stage.
// The state encoding is fixed so other stages can decode it; 2'd3 is unused.
package button_debounce_repeat_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Both flops reset to RESET_VAL so the output starts at a known idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/button_debounce_repeat.sv
// Synchronises and debounces one push-button, emitting press/release pulses and
// auto-repeat pulses while held; step is the downstream counter's increment strobe.
module button_debounce_repeat
  import button_debounce_repeat_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned HOLD_CYCLES     = 6000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000,
  parameter bit          ACTIVE_LOW_BTN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES);
  localparam logic [TmW-1:0] HoldLast = TmW'(HOLD_CYCLES - 1);
  localparam logic [TmW-1:0] RepLast  = TmW'(REPEAT_CYCLES - 1);

  logic           sync_pin;
  logic           sync_pressed;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           rise, fall;
  state_e         state_q, state_d;
  logic [TmW-1:0] tmr_q, tmr_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           repeat_q, repeat_d;
  logic           step_q, step_d;

  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW_BTN)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (btn_in),
    .q_o    (sync_pin)
  );

  assign sync_pressed = sync_pin ^ ACTIVE_LOW_BTN;

  // The counter holds DEBOUNCE_CYCLES for one cycle before the level flips.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_pressed != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= StIdle;
      tmr_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHold;
          tmr_d   = '0;
        end
      end
      StHold: begin
        if (fall) begin
          state_d = StIdle;
        end else if (tmr_q == HoldLast) begin
          state_d = StRepeat;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmW'(1);
        end
      end
      StRepeat: begin
        if (fall) begin
          state_d = StIdle;
        end else if (tmr_q == RepLast) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + TmW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase
  end

  // A release in the same cycle as a due repeat suppresses the repeat.
  always_comb begin
    press_d   = (state_q == StIdle) & rise;
    release_d = ((state_q == StHold) | (state_q == StRepeat)) & fall;
    repeat_d  = ~fall & (((state_q == StHold) & (tmr_q == HoldLast)) |
                         ((state_q == StRepeat) & (tmr_q == RepLast)));
    step_d    = press_d | repeat_d;
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step          = step_q;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Directed bench: each press schedules its expected pulses into a per-DUT
// queue, and a negedge monitor pops and compares them every cycle.
module tb_button_debounce_repeat;
  import button_debounce_repeat_pkg::*;

  localparam int unsigned Deb = 4;
  localparam int unsigned Hold = 20;
  localparam int unsigned Rep = 5;
  // From the cycle the pin is driven to the cycle the pulse is visible.
  localparam int unsigned Lat = Deb + 3;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  vec;  // {press, release, repeat, step}
  } ev_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, btn_a, btn_b;
  logic lvl_a, prs_a, rel_a, rpt_a, stp_a;
  logic lvl_b, prs_b, rel_b, rpt_b, stp_b;

  ev_t         q_a[$];
  ev_t         q_b[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        lvl_exp_a = 1'b0;
  logic        lvl_exp_b = 1'b0;

  button_debounce_repeat #(
    .DEBOUNCE_CYCLES (Deb),
    .HOLD_CYCLES     (Hold),
    .REPEAT_CYCLES   (Rep),
    .ACTIVE_LOW_BTN  (1'b1)
  ) dut_a (
    .clk           (clk),
    .rst           (rst_a),
    .btn_in        (btn_a),
    .btn_level     (lvl_a),
    .press_pulse   (prs_a),
    .release_pulse (rel_a),
    .repeat_pulse  (rpt_a),
    .step          (stp_a)
  );

  button_debounce_repeat #(
    .DEBOUNCE_CYCLES (Deb),
    .HOLD_CYCLES     (Hold),
    .REPEAT_CYCLES   (Rep),
    .ACTIVE_LOW_BTN  (1'b0)
  ) dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .btn_in        (btn_b),
    .btn_level     (lvl_b),
    .press_pulse   (prs_b),
    .release_pulse (rel_b),
    .repeat_pulse  (rpt_b),
    .step          (stp_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Pin held pressed for n cycles starting at cycle c0: press, repeats strictly
  // before the release, then the release (which wins over a coincident repeat).
  task automatic schedule(input bit which, input int unsigned c0, input int unsigned n);
    ev_t         e;
    int unsigned p, f, t;
    p = c0 + Lat;
    f = c0 + n + Lat;
    e.cyc = p; e.vec = 4'b1001;
    if (which) q_b.push_back(e); else q_a.push_back(e);
    t = p + Hold;
    while (t < f) begin
      e.cyc = t; e.vec = 4'b0011;
      if (which) q_b.push_back(e); else q_a.push_back(e);
      t += Rep;
    end
    e.cyc = f; e.vec = 4'b0100;
    if (which) q_b.push_back(e); else q_a.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ev_t        e;
    logic [3:0] va, vb;
    va = '0;
    vb = '0;
    if (q_a.size() > 0 && q_a[0].cyc == cyc) begin e = q_a.pop_front(); va = e.vec; end
    if (q_b.size() > 0 && q_b[0].cyc == cyc) begin e = q_b.pop_front(); vb = e.vec; end
    if (va[3]) lvl_exp_a = 1'b1;
    if (va[2]) lvl_exp_a = 1'b0;
    if (vb[3]) lvl_exp_b = 1'b1;
    if (vb[2]) lvl_exp_b = 1'b0;
    check("dut_a_outputs", {lvl_a, prs_a, rel_a, rpt_a, stp_a}, {lvl_exp_a, va});
    check("dut_b_outputs", {lvl_b, prs_b, rel_b, rpt_b, stp_b}, {lvl_exp_b, vb});
  end

  initial begin
    int unsigned c;
    rst_a = 1'b0;
    rst_b = 1'b0;
    btn_a = 1'b1;
    btn_b = 1'b0;
    wait_cycles(3);
    check("reset_fsm_a", {3'b000, dut_a.state_q}, {3'b000, StIdle});
    check("reset_fsm_b", {3'b000, dut_b.state_q}, {3'b000, StIdle});
    rst_a = 1'b1;
    rst_b = 1'b1;
    wait_cycles(3);

    // Three-cycle glitch: nothing scheduled, monitor expects silence.
    btn_a = 1'b0;
    wait_cycles(3);
    btn_a = 1'b1;
    wait_cycles(15);

    // Short press, no repeat.
    schedule(1'b0, cyc, 15);
    btn_a = 1'b0;
    wait_cycles(15);
    btn_a = 1'b1;
    wait_cycles(15);

    // Long hold with several repeats.
    schedule(1'b0, cyc, 50);
    btn_a = 1'b0;
    wait_cycles(50);
    btn_a = 1'b1;
    wait_cycles(15);

    // Release lands exactly on a due repeat.
    schedule(1'b0, cyc, Hold + 3 * Rep);
    btn_a = 1'b0;
    wait_cycles(Hold + 3 * Rep);
    btn_a = 1'b1;
    wait_cycles(Lat + 1);
    check("collide_fsm_idle", {3'b000, dut_a.state_q}, {3'b000, StIdle});
    wait_cycles(7);

    // Active-high pin: reset while in REPEAT, then press is re-debounced.
    c = cyc;
    schedule(1'b1, c, 1000);
    btn_b = 1'b1;
    wait_cycles(Lat + Hold + 3);
    check("hold_fsm_repeat", {3'b000, dut_b.state_q}, {3'b000, StRepeat});
    rst_b = 1'b0;
    q_b.delete();
    lvl_exp_b = 1'b0;
    #1;
    check("rst_mid_hold_clear", {lvl_b, prs_b, rel_b, rpt_b, stp_b}, 5'b00000);
    wait_cycles(2);
    rst_b = 1'b1;
    schedule(1'b1, cyc, 10);
    wait_cycles(10);
    btn_b = 1'b0;
    wait_cycles(15);

    check("scoreboard_drained", 5'(q_a.size() + q_b.size()), 5'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
